// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812B definitions used by the receiver and transmitter.
//   cycles()      time-to-clock-cycle conversion, rounded to nearest
//   *_NOM         nominal WS2812B line timing (seconds)
//   grb_to_rgb()  wire-order GRB word to {R,G,B}
//   rgb_to_grb()  {R,G,B} to wire-order GRB word
//   rx_state_t    receiver state encoding; ST_FORWARD exists only when
//                 WS2812_RX_FORWARD_EN is defined
package ws2812_pkg;

  localparam real T0H_NOM   = 0.40e-6;
  localparam real T0L_NOM   = 0.85e-6;
  localparam real T1H_NOM   = 0.80e-6;
  localparam real T1L_NOM   = 0.45e-6;
  localparam real RESET_NOM = 50.0e-6;

  // The small bias keeps exact halves (e.g. 40.5) from landing just below
  // .5 because of the binary representation of decimal times.
  function automatic int cycles(real t, int f);
    return int'($rtoi(t * real'(f) + 0.5 + 1.0e-6));
  endfunction

  function automatic logic [23:0] grb_to_rgb(logic [23:0] w);
    return {w[15:8], w[23:16], w[7:0]};
  endfunction

  function automatic logic [23:0] rgb_to_grb(logic [23:0] c);
    return {c[15:8], c[23:16], c[7:0]};
  endfunction

  typedef enum logic [2:0] {
    ST_WAIT_RESET,
    ST_IDLE,
    ST_HIGH,
`ifdef WS2812_RX_FORWARD_EN
    ST_LOW,
    ST_FORWARD
`else
    ST_LOW
`endif
  } rx_state_t;

endpackage

// File: rtl/ws2812_sync.sv
// ws2812_sync: two-flop synchronizer for the asynchronous serial line with
// registered edge strobes. The strobes are aligned with the cycle in which
// the synchronized level first shows the new value.
//   clk   in   system clock
//   rst   in   synchronous, active-low reset
//   din   in   asynchronous serial input
//   sync  out  synchronized level
//   rise  out  one-cycle strobe on a synchronized rising edge
//   fall  out  one-cycle strobe on a synchronized falling edge
module ws2812_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic rise_p1;
  logic fall_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
    end else begin
      // stage 0: capture
      meta_p0 <= din;
      // stage 1: synchronized level and its edges
      sync_p1 <= meta_p0;
      rise_p1 <= meta_p0 & ~sync_p1;
      fall_p1 <= ~meta_p0 & sync_p1;
    end
  end

  assign sync = sync_p1;
  assign rise = rise_p1;
  assign fall = fall_p1;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812B single-wire receiver. Classifies high pulses by width,
// assembles 24-bit GRB words MSB first and presents them as {R,G,B}.
// Optional chain mode (macro WS2812_RX_FORWARD_EN): after the first word of
// a frame the line is forwarded to dout instead of decoded.
//   clk         in   system clock
//   rst         in   synchronous, active-low reset
//   din         in   asynchronous serial input
//   rgb_data    out  last received word as {R,G,B}
//   data_valid  out  one-cycle pulse when rgb_data updates
//   frame_end   out  one-cycle pulse when the latch low period completes
//   bit_error   out  one-cycle pulse on a malformed pulse or truncated word
//   busy        out  high while a frame is in progress
//   dout        out  forwarded serial output (0 unless chain mode)
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int  CLK_FREQ    = 27_000_000,
  parameter real THRESH_time = 0.6e-6,
  parameter real HI_MIN_time = 0.15e-6,
  parameter real HI_MAX_time = 1.5e-6,
  parameter real RESET_time  = 50.0e-6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic        data_valid,
  output logic        frame_end,
  output logic        bit_error,
  output logic        busy,
  output logic        dout
);

  localparam logic [15:0] THRESH_C = 16'(cycles(THRESH_time, CLK_FREQ));
  localparam logic [15:0] HI_MIN_C = 16'(cycles(HI_MIN_time, CLK_FREQ));
  localparam logic [15:0] HI_MAX_C = 16'(cycles(HI_MAX_time, CLK_FREQ));
  localparam logic [15:0] RESET_C  = 16'(cycles(RESET_time, CLK_FREQ));

  function automatic logic [15:0] sat_inc16(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [4:0] sat_inc5(logic [4:0] v);
    return (v == 5'h1F) ? v : v + 5'd1;
  endfunction

  logic sync, rise, fall;

  ws2812_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  rx_state_t   state, state_next;
  logic [15:0] hi_cnt, hi_next;
  logic [15:0] lo_cnt, lo_next;
  logic [4:0]  bit_cnt, bit_next;
  logic [23:0] word, word_next, shifted;
  logic [23:0] rgb_next;
  logic        dv_next, fe_next, be_next;
`ifdef WS2812_RX_FORWARD_EN
  logic        dout_p2, dout_next;
`endif

  always_comb begin
    state_next = state;
    hi_next    = hi_cnt;
    lo_next    = lo_cnt;
    bit_next   = bit_cnt;
    word_next  = word;
    rgb_next   = rgb_data;
    dv_next    = 1'b0;
    fe_next    = 1'b0;
    be_next    = 1'b0;
    shifted    = {word[22:0], (hi_cnt >= THRESH_C)};
`ifdef WS2812_RX_FORWARD_EN
    dout_next  = 1'b0;
`endif
    case (state)
      ST_WAIT_RESET: begin
        if (sync) begin
          lo_next = '0;
        end else if (lo_cnt >= RESET_C) begin
          lo_next    = '0;
          state_next = ST_IDLE;
        end else begin
          lo_next = sat_inc16(lo_cnt);
        end
      end
      ST_IDLE: begin
        if (rise) begin
          hi_next    = 16'd1;
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        hi_next = sat_inc16(hi_cnt);
        // Over-long pulses are caught while still high; short ones on the fall.
        if ((hi_cnt > HI_MAX_C) || (fall && (hi_cnt < HI_MIN_C))) begin
          be_next    = 1'b1;
          bit_next   = '0;
          lo_next    = '0;
          state_next = ST_WAIT_RESET;
        end else if (fall) begin
          word_next  = shifted;
          lo_next    = 16'd1;
          state_next = ST_LOW;
          if (bit_cnt == 5'd23) begin
            rgb_next = grb_to_rgb(shifted);
            dv_next  = 1'b1;
            bit_next = '0;
`ifdef WS2812_RX_FORWARD_EN
            state_next = ST_FORWARD;
`endif
          end else begin
            bit_next = sat_inc5(bit_cnt);
          end
        end
      end
      ST_LOW: begin
        lo_next = sat_inc16(lo_cnt);
        if (lo_cnt >= RESET_C) begin
          fe_next    = 1'b1;
          be_next    = (bit_cnt != '0);
          bit_next   = '0;
          state_next = ST_IDLE;
        end else if (rise) begin
          hi_next    = 16'd1;
          state_next = ST_HIGH;
        end
      end
`ifdef WS2812_RX_FORWARD_EN
      ST_FORWARD: begin
        dout_next = sync;
        lo_next   = sync ? 16'd0 : sat_inc16(lo_cnt);
        if (lo_cnt >= RESET_C) begin
          fe_next    = 1'b1;
          dout_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_WAIT_RESET;
    endcase
  end

  // stage 2: decoder state and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_WAIT_RESET;
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      bit_cnt    <= '0;
      rgb_data   <= '0;
      data_valid <= 1'b0;
      frame_end  <= 1'b0;
      bit_error  <= 1'b0;
`ifdef WS2812_RX_FORWARD_EN
      dout_p2    <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      hi_cnt     <= hi_next;
      lo_cnt     <= lo_next;
      bit_cnt    <= bit_next;
      rgb_data   <= rgb_next;
      data_valid <= dv_next;
      frame_end  <= fe_next;
      bit_error  <= be_next;
`ifdef WS2812_RX_FORWARD_EN
      dout_p2    <= dout_next;
`endif
    end
  end

  // Shift register holds only data; bit_cnt decides what of it is valid.
  always_ff @(posedge clk) begin
    word <= word_next;
  end

`ifdef WS2812_RX_FORWARD_EN
  assign busy = (state == ST_HIGH) || (state == ST_LOW) || (state == ST_FORWARD);
  assign dout = dout_p2;
`else
  assign busy = (state == ST_HIGH) || (state == ST_LOW);
  assign dout = 1'b0;
`endif

endmodule
